context_sign_restore: RTL and testbench

- Decoder-side counterpart of the encoder's context-sign stage in the JPEG-LS datapath.
- Takes the raw context vector (Q1, Q2, Q3), the decoded prediction error and the corrected prediction Px. It determines the context sign and emits the sign-normalised vector for context lookup.
- Restores the sign of the error, then reconstructs the sample Rx with modulo-range reduction and clamping.
- 3-stage valid/ready pipeline between the Golomb decoder and the reconstructed-sample writer.

---
 rtl/context_sign_restore_pkg.sv | 62 ++++++
 rtl/context_sign_restore_norm.sv | 30 +++
 rtl/context_sign_restore.sv | 129 ++++++++++++
 tb/tb_context_sign_restore.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/context_sign_restore_pkg.sv
// Shared constants, stage payload types and the modulo-range/clamp helper
// used by the JPEG-LS decoder context-sign restore stage.
package context_sign_restore_pkg;

  localparam int Q_LENGTH = 4;
  localparam int BPP      = 8;
  localparam int ERR_W    = BPP + 1;
  localparam int MAXVAL   = (1 << BPP) - 1;
  localparam int RANGE    = MAXVAL + 1;
  // Px (0..MAXVAL) plus a restored error of up to +/-2^(ERR_W-1) needs two guard bits.
  localparam int SUM_W    = BPP + 2;

  localparam logic signed [SUM_W-1:0] RANGE_S  = SUM_W'(RANGE);
  localparam logic signed [SUM_W-1:0] MAXVAL_S = SUM_W'(MAXVAL);

  typedef logic signed [Q_LENGTH-1:0] q_t;

  typedef struct packed {
    logic sign;
    q_t   q1;
    q_t   q2;
    q_t   q3;
  } ctx_t;

  typedef struct packed {
    ctx_t                    ctx;
    logic signed [ERR_W-1:0] err;
    logic [BPP-1:0]          px;
  } s1_t;

  typedef struct packed {
    ctx_t                    ctx;
    logic signed [SUM_W-1:0] sum;
  } s2_t;

  typedef struct packed {
    ctx_t           ctx;
    logic [BPP-1:0] rx;
  } s3_t;

  // Fold the sum back into one RANGE window, then clamp to the sample range.
  function automatic logic [BPP-1:0] wrap_clamp(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] w;
    logic [BPP-1:0]          r;
    if (sum[SUM_W-1]) begin
      w = sum + RANGE_S;
    end else if (sum > MAXVAL_S) begin
      w = sum - RANGE_S;
    end else begin
      w = sum;
    end
    if (w[SUM_W-1]) begin
      r = '0;
    end else if (w > MAXVAL_S) begin
      r = BPP'(MAXVAL);
    end else begin
      r = w[BPP-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/context_sign_restore_norm.sv
// Combinational context sign detection and normalisation; shared with the
// encoder so both sides derive an identical sign from (Q1, Q2, Q3).
module context_sign_norm
  import context_sign_restore_pkg::*;
(
  input  q_t   q1,
  input  q_t   q2,
  input  q_t   q3,
  output logic sign,
  output q_t   q1_n,
  output q_t   q2_n,
  output q_t   q3_n
);

  always_comb begin
    sign = 1'b0;
    if (q1 != '0) begin
      sign = q1[Q_LENGTH-1];
    end else if (q2 != '0) begin
      sign = q2[Q_LENGTH-1];
    end else begin
      sign = q3[Q_LENGTH-1];
    end
  end

  assign q1_n = sign ? -q1 : q1;
  assign q2_n = sign ? -q2 : q2;
  assign q3_n = sign ? -q3 : q3;

endmodule

// File: rtl/context_sign_restore.sv
// Three-stage valid/ready pipeline: context sign normalisation, error sign
// restore plus prediction add, then modulo reduction and clamp to Rx.
module context_sign_restore
  import context_sign_restore_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Q_LENGTH-1:0] q1_in,
  input  logic [Q_LENGTH-1:0] q2_in,
  input  logic [Q_LENGTH-1:0] q3_in,
  input  logic [ERR_W-1:0]    err_in,
  input  logic [BPP-1:0]      px_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign_out,
  output logic [Q_LENGTH-1:0] q1_out,
  output logic [Q_LENGTH-1:0] q2_out,
  output logic [Q_LENGTH-1:0] q3_out,
  output logic [BPP-1:0]      rx_out
);

  logic ready_en_q, ready_en_d;
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;

  logic adv1, adv2, adv3;
  logic in_fire;

  logic norm_sign;
  q_t   norm_q1, norm_q2, norm_q3;

  logic signed [ERR_W:0]   err_ext;
  logic signed [ERR_W:0]   errval;
  logic signed [SUM_W-1:0] sum;

  assign adv3     = !v3_q || out_ready;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  // Input side stays closed until the first clock after reset release.
  assign in_ready = adv1 && ready_en_q;
  assign in_fire  = in_valid && in_ready;

  context_sign_norm u_norm (
    .q1   (q_t'(q1_in)),
    .q2   (q_t'(q2_in)),
    .q3   (q_t'(q3_in)),
    .sign (norm_sign),
    .q1_n (norm_q1),
    .q2_n (norm_q2),
    .q3_n (norm_q3)
  );

  // One extra bit so that negating the most negative error cannot overflow.
  assign err_ext = (ERR_W + 1)'(s1_q.err);
  assign errval  = s1_q.ctx.sign ? -err_ext : err_ext;
  assign sum     = SUM_W'(errval) + SUM_W'(signed'({1'b0, s1_q.px}));

  always_comb begin
    ready_en_d = 1'b1;
    v1_d       = v1_q;
    v2_d       = v2_q;
    v3_d       = v3_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;

    if (adv1) begin
      v1_d = in_fire;
      if (in_fire) begin
        s1_d.ctx.sign = norm_sign;
        s1_d.ctx.q1   = norm_q1;
        s1_d.ctx.q2   = norm_q2;
        s1_d.ctx.q3   = norm_q3;
        s1_d.err      = signed'(err_in);
        s1_d.px       = px_in;
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d.ctx = s1_q.ctx;
        s2_d.sum = sum;
      end
    end

    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        s3_d.ctx = s2_q.ctx;
        s3_d.rx  = wrap_clamp(s2_q.sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
    end
  end

  assign out_valid = v3_q;
  assign sign_out  = s3_q.ctx.sign;
  assign q1_out    = s3_q.ctx.q1;
  assign q2_out    = s3_q.ctx.q2;
  assign q3_out    = s3_q.ctx.q3;
  assign rx_out    = s3_q.rx;

endmodule

// File: tb/tb_context_sign_restore.sv
// Directed-vector bench for context_sign_restore: reset, single beats with
// latency, back-to-back streaming under output stall, and mid-stream reset.
module tb_context_sign_restore;

  typedef struct {
    logic [3:0] q1, q2, q3;
    logic [8:0] err;
    logic [7:0] px;
    logic       sign;
    logic [3:0] o1, o2, o3;
    logic [7:0] rx;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] q1_in, q2_in, q3_in;
  logic [8:0] err_in;
  logic [7:0] px_in;
  logic       out_valid;
  logic       out_ready;
  logic       sign_out;
  logic [3:0] q1_out, q2_out, q3_out;
  logic [7:0] rx_out;

  int checks = 0;
  int errors = 0;

  context_sign_restore dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q1_in     (q1_in),
    .q2_in     (q2_in),
    .q3_in     (q3_in),
    .err_in    (err_in),
    .px_in     (px_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .q1_out    (q1_out),
    .q2_out    (q2_out),
    .q3_out    (q3_out),
    .rx_out    (rx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({sign_out, q1_out, q2_out, q3_out, rx_out} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sign=%b q=%h,%h,%h rx=%0d want all 0", sign_out, q1_out, q2_out, q3_out, rx_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    $display("reset: released, in_ready=%b", in_ready);
  endtask

  task automatic test_directed();
    vec_t dir [6];
    int   lat;
    bit   acc;
    dir[0] = '{4'h0, 4'hD, 4'h2, 9'd5,    8'd100, 1'b1, 4'h0, 4'h3, 4'hE, 8'd95};
    dir[1] = '{4'h2, 4'hF, 4'h0, 9'h1F9,  8'd3,   1'b0, 4'h2, 4'hF, 4'h0, 8'd252};
    dir[2] = '{4'h0, 4'h0, 4'h0, 9'd10,   8'd250, 1'b0, 4'h0, 4'h0, 4'h0, 8'd4};
    dir[3] = '{4'hF, 4'h0, 4'h0, 9'h100,  8'd0,   1'b1, 4'h1, 4'h0, 4'h0, 8'd0};
    dir[4] = '{4'h0, 4'h0, 4'hC, 9'd20,   8'd10,  1'b1, 4'h0, 4'h0, 4'h4, 8'd246};
    dir[5] = '{4'hF, 4'h0, 4'h0, 9'h100,  8'd255, 1'b1, 4'h1, 4'h0, 4'h0, 8'd255};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      q1_in = dir[i].q1; q2_in = dir[i].q2; q3_in = dir[i].q3;
      err_in = dir[i].err; px_in = dir[i].px;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL case%0d_accept: got in_ready=%b want 1", i, acc); end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL case%0d_latency: got %0d want 3", i, lat); end
      checks++;
      if ({sign_out, q1_out, q2_out, q3_out} !== {dir[i].sign, dir[i].o1, dir[i].o2, dir[i].o3}) begin
        errors++;
        $display("FAIL case%0d_ctx: got sign=%b q=%h,%h,%h want sign=%b q=%h,%h,%h", i,
                 sign_out, q1_out, q2_out, q3_out, dir[i].sign, dir[i].o1, dir[i].o2, dir[i].o3);
      end
      checks++;
      if (rx_out !== dir[i].rx) begin errors++; $display("FAIL case%0d_rx: got %0d want %0d", i, rx_out, dir[i].rx); end
      $display("case%0d: sign=%b q=%h,%h,%h rx=%0d latency=%0d", i, sign_out, q1_out, q2_out, q3_out, rx_out, lat);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL case%0d_drain: got out_valid=%b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t  bb [8];
    int    sent = 0;
    int    recv = 0;
    bit    saw_block = 0;
    bit    prev_hold = 0;
    bit    extra = 0;
    logic [21:0] prev_bus = '0;
    logic [21:0] cur_bus;
    bb[0] = '{4'h1, 4'h0, 4'h0, 9'd1,   8'd10,  1'b0, 4'h1, 4'h0, 4'h0, 8'd11};
    bb[1] = '{4'hE, 4'h1, 4'h0, 9'd3,   8'd50,  1'b1, 4'h2, 4'hF, 4'h0, 8'd47};
    bb[2] = '{4'h0, 4'h0, 4'h0, 9'h1FF, 8'd0,   1'b0, 4'h0, 4'h0, 4'h0, 8'd255};
    bb[3] = '{4'h0, 4'h2, 4'hD, 9'd4,   8'd200, 1'b0, 4'h0, 4'h2, 4'hD, 8'd204};
    bb[4] = '{4'h0, 4'h0, 4'h3, 9'd100, 8'd200, 1'b0, 4'h0, 4'h0, 4'h3, 8'd44};
    bb[5] = '{4'h0, 4'hF, 4'hF, 9'h1F6, 8'd5,   1'b1, 4'h0, 4'h1, 4'h1, 8'd15};
    bb[6] = '{4'hC, 4'h3, 4'h3, 9'd0,   8'd77,  1'b1, 4'h4, 4'hD, 4'hD, 8'd77};
    bb[7] = '{4'h3, 4'hC, 4'h2, 9'h101, 8'd255, 1'b0, 4'h3, 4'hC, 4'h2, 8'd0};
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 8) begin
        in_valid = 1'b1;
        q1_in = bb[sent].q1; q2_in = bb[sent].q2; q3_in = bb[sent].q3;
        err_in = bb[sent].err; px_in = bb[sent].px;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      cur_bus = {out_valid, sign_out, q1_out, q2_out, q3_out, rx_out};
      if (prev_hold) begin
        checks++;
        if (cur_bus !== prev_bus) begin
          errors++;
          $display("FAIL stall_stable cyc%0d: got %h want %h", cyc, cur_bus, prev_bus);
        end
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if ({sign_out, q1_out, q2_out, q3_out, rx_out} !==
            {bb[recv].sign, bb[recv].o1, bb[recv].o2, bb[recv].o3, bb[recv].rx}) begin
          errors++;
          $display("FAIL b2b_beat%0d: got sign=%b q=%h,%h,%h rx=%0d want sign=%b q=%h,%h,%h rx=%0d", recv,
                   sign_out, q1_out, q2_out, q3_out, rx_out,
                   bb[recv].sign, bb[recv].o1, bb[recv].o2, bb[recv].o3, bb[recv].rx);
        end
        $display("b2b: beat%0d out at cyc%0d rx=%0d", recv, cyc, rx_out);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_hold = out_valid && !out_ready;
      prev_bus  = cur_bus;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid) extra = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (recv != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", recv); end
    checks++;
    if (sent != 8) begin errors++; $display("FAIL b2b_sent: got %0d want 8", sent); end
    checks++;
    if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: got in_ready never low, want a drop"); end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL b2b_extra: got extra output beat, want none"); end
  endtask

  task automatic test_reset_mid_stream();
    int got = 0;
    logic [7:0] got_rx = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      q1_in = 4'h1; q2_in = 4'h0; q3_in = 4'h0; err_in = 9'(i + 1); px_in = 8'd20;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got out_valid=%b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (rx_out !== 8'd0) begin errors++; $display("FAIL midrst_rx: got %0d want 0", rx_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q1_in = 4'h0; q2_in = 4'h0; q3_in = 4'h0; err_in = 9'd10; px_in = 8'd250;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) begin
        got++;
        got_rx = rx_out;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 1) begin errors++; $display("FAIL midrst_count: got %0d beats want 1", got); end
    checks++;
    if (got_rx !== 8'd4) begin errors++; $display("FAIL midrst_new_rx: got %0d want 4", got_rx); end
    $display("midrst: %0d beat(s) after release, rx=%0d", got, got_rx);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    q1_in = '0; q2_in = '0; q3_in = '0;
    err_in = '0; px_in = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
